// File: rtl/complex_deser_1to4_pkg.sv
// Shared FFT datapath definitions for the 1-to-4 complex deserializer:
// sample format, lane count and lane index type.
package complex_deser_1to4_pkg;

  localparam int WL_DEF     = 14;          // MSB index of S3.11 words
  localparam int FRAC_BITS  = 11;
  localparam logic signed [WL_DEF:0] ONE = 15'sh0800;
  localparam int LANES      = 4;
  localparam int LANE_IDX_W = 2;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/complex_deser_1to4_if.sv
// Serial complex input stream plus registered four-lane parallel output.
// slave = deserializer, master = source/sink driving it.
interface complex_deser_1to4_if #(parameter int WL = 14);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [WL:0]   in_real;
  logic signed [WL:0]   in_imag;
  logic                 frame_sync;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [WL:0]   O0_real, O1_real, O2_real, O3_real;
  logic signed [WL:0]   O0_imag, O1_imag, O2_imag, O3_imag;
  logic                 partial_drop;

  modport slave (
    input  in_valid, in_real, in_imag, frame_sync, out_ready,
    output in_ready, out_valid, partial_drop,
           O0_real, O1_real, O2_real, O3_real,
           O0_imag, O1_imag, O2_imag, O3_imag
  );

  modport master (
    output in_valid, in_real, in_imag, frame_sync, out_ready,
    input  in_ready, out_valid, partial_drop,
           O0_real, O1_real, O2_real, O3_real,
           O0_imag, O1_imag, O2_imag, O3_imag
  );

endinterface

// File: rtl/complex_deser_1to4_lane_decode.sv
// Write index to one-hot lane enable. DESER_BITREV_EN selects digit-reversed
// order (0,2,1,3); otherwise lanes are filled in natural order.
module lane_decode_1to4
  import complex_deser_1to4_pkg::*;
(
  input  lane_idx_t          idx_i,
  output logic [LANES-1:0]   en_o
);

  always_comb begin
    en_o = '0;
`ifdef DESER_BITREV_EN
    en_o[{idx_i[0], idx_i[1]}] = 1'b1;
`else
    en_o[idx_i] = 1'b1;
`endif
  end

endmodule

// File: rtl/complex_deser_1to4.sv
// Serial-to-parallel complex demux: four accepted samples become one
// registered parallel group. Lane order is set by DESER_BITREV_EN.
module complex_deser_1to4
  import complex_deser_1to4_pkg::*;
#(
  parameter int WL = WL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  complex_deser_1to4_if.slave   bus
);

  logic                         acc, done;
  lane_idx_t                    wr_cnt_q, wr_cnt_d, idx;
  logic [LANES-1:0]             lane_en;
  logic [LANES-2:0][WL:0]       st_re_q, st_im_q;
  logic [LANES-1:0][WL:0]       o_re_q, o_im_q;
  logic                         out_valid_q, partial_drop_q;

  // Only the group-completing sample can be back-pressured by a held output.
  assign bus.in_ready = (wr_cnt_q != 2'd3) || !out_valid_q || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;
  assign idx          = bus.frame_sync ? lane_idx_t'(0) : wr_cnt_q;
  assign done         = acc && !bus.frame_sync && (wr_cnt_q == 2'd3);
  assign wr_cnt_d     = bus.frame_sync ? lane_idx_t'(1) : wr_cnt_q + 2'd1;

  lane_decode_1to4 u_dec (
    .idx_i (idx),
    .en_o  (lane_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q       <= '0;
      st_re_q        <= '0;
      st_im_q        <= '0;
      o_re_q         <= '0;
      o_im_q         <= '0;
      out_valid_q    <= 1'b0;
      partial_drop_q <= 1'b0;
    end else begin
      partial_drop_q <= acc && bus.frame_sync && (wr_cnt_q != 2'd0);
      if (acc) wr_cnt_q <= wr_cnt_d;
      for (int l = 0; l < LANES-1; l++) begin
        if (acc && lane_en[l]) begin
          st_re_q[l] <= bus.in_real;
          st_im_q[l] <= bus.in_imag;
        end
      end
      if (done) begin
        o_re_q      <= {bus.in_real, st_re_q};
        o_im_q      <= {bus.in_imag, st_im_q};
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.partial_drop = partial_drop_q;
  assign bus.O0_real = o_re_q[0];
  assign bus.O1_real = o_re_q[1];
  assign bus.O2_real = o_re_q[2];
  assign bus.O3_real = o_re_q[3];
  assign bus.O0_imag = o_im_q[0];
  assign bus.O1_imag = o_im_q[1];
  assign bus.O2_imag = o_im_q[2];
  assign bus.O3_imag = o_im_q[3];

endmodule

// File: tb/tb_complex_deser_1to4.sv
// Directed bench for complex_deser_1to4: expected groups are queued as
// samples are issued, a negedge monitor pops them on each consumed group.
module tb_complex_deser_1to4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  complex_deser_1to4_if #(.WL(14)) bus ();

  complex_deser_1to4 #(.WL(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int vld_cyc = 0;
  int pd_cnt = 0;
  int stalls = 0;
  logic [119:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Arguments in accept order; the stored group is in output-lane order.
  task automatic exp4(input logic [14:0] r0, i0, r1, i1, r2, i2, r3, i3);
`ifdef DESER_BITREV_EN
    exp_q.push_back({r0, i0, r2, i2, r1, i1, r3, i3});
`else
    exp_q.push_back({r0, i0, r1, i1, r2, i2, r3, i3});
`endif
  endtask

  task automatic send(input logic [14:0] r, input logic [14:0] im, input logic fs);
    int n;
    bus.in_valid   = 1'b1;
    bus.in_real    = r;
    bus.in_imag    = im;
    bus.frame_sync = fs;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      stalls++;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, required 1", n);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.frame_sync = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic [119:0] got, e;
      if (bus.out_valid)    vld_cyc++;
      if (bus.partial_drop) pd_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        got = {bus.O0_real, bus.O0_imag, bus.O1_real, bus.O1_imag,
               bus.O2_real, bus.O2_imag, bus.O3_real, bus.O3_imag};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL group_unexpected: got %h, no group expected", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL group_data: got %h expected %h", got, e);
          end
        end
      end
    end
  end

  initial begin
    int v0, p0, s0;
    bus.in_valid   = 1'b0;
    bus.in_real    = '0;
    bus.in_imag    = '0;
    bus.frame_sync = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_partial_drop", 32'(bus.partial_drop), 32'd0);
    chk("rst_O0_real", 32'(bus.O0_real), 32'd0);
    chk("rst_O3_imag", 32'(bus.O3_imag), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Basic group, out_valid must be a single-cycle pulse
    v0 = vld_cyc;
    exp4(15'h0800, 15'h7800, 15'h0400, 15'h0000, 15'h7C00, 15'h0200, 15'h0001, 15'h7FFF);
    send(15'h0800, 15'h7800, 0);
    send(15'h0400, 15'h0000, 0);
    send(15'h7C00, 15'h0200, 0);
    send(15'h0001, 15'h7FFF, 0);
    repeat (3) @(negedge clk);
    chk("t1_valid_cycles", 32'(vld_cyc - v0), 32'd1);
    @(posedge clk); #1;

    // Sustained stream of 12 samples
    v0 = vld_cyc; s0 = stalls;
    for (int g = 0; g < 3; g++) begin
      logic [14:0] b;
      b = 15'(16 * g + 16);
      exp4(b, ~b, b + 15'd1, ~b + 15'd1, b + 15'd2, ~b + 15'd2, b + 15'd3, ~b + 15'd3);
    end
    for (int k = 0; k < 12; k++) begin
      logic [14:0] b;
      b = 15'(16 * (k / 4) + 16);
      send(b + 15'(k % 4), ~b + 15'(k % 4), 0);
    end
    repeat (3) @(negedge clk);
    chk("t2_stalls", 32'(stalls - s0), 32'd0);
    chk("t2_valid_cycles", 32'(vld_cyc - v0), 32'd3);
    @(posedge clk); #1;

    // Output held: lanes 0-2 keep filling, completing sample stalls
    bus.out_ready = 1'b0;
    s0 = stalls;
    exp4(15'h0111, 15'h0011, 15'h0222, 15'h0022, 15'h0333, 15'h0033, 15'h0444, 15'h0044);
    exp4(15'h0555, 15'h0055, 15'h0666, 15'h0066, 15'h0777, 15'h0077, 15'h0888, 15'h0088);
    send(15'h0111, 15'h0011, 0);
    send(15'h0222, 15'h0022, 0);
    send(15'h0333, 15'h0033, 0);
    send(15'h0444, 15'h0044, 0);
    send(15'h0555, 15'h0055, 0);
    send(15'h0666, 15'h0066, 0);
    send(15'h0777, 15'h0077, 0);
    chk("t3_lane_stalls", 32'(stalls - s0), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_real  = 15'h0888;
    bus.in_imag  = 15'h0088;
    @(negedge clk);
    chk("t3_in_ready_stall", 32'(bus.in_ready), 32'd0);
    chk("t3_hold_O0", 32'(bus.O0_real), 32'h0111);
    @(posedge clk); #1;
    chk("t3_hold_O3", 32'(bus.O3_imag), 32'h0044);
    bus.out_ready = 1'b1;
    send(15'h0888, 15'h0088, 0);
    repeat (2) @(negedge clk);
    chk("t3_queue_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // frame_sync mid-group drops the partial group
    p0 = pd_cnt;
    exp4(15'h0123, 15'h0321, 15'h0010, 15'h0020, 15'h0030, 15'h0040, 15'h0050, 15'h0060);
    send(15'h7001, 15'h7002, 0);
    send(15'h7003, 15'h7004, 0);
    send(15'h0123, 15'h0321, 1);
    send(15'h0010, 15'h0020, 0);
    send(15'h0030, 15'h0040, 0);
    send(15'h0050, 15'h0060, 0);
    repeat (2) @(negedge clk);
    chk("t4_partial_drop_pulses", 32'(pd_cnt - p0), 32'd1);
    @(posedge clk); #1;

    // frame_sync on a group boundary is a plain lane-0 write
    p0 = pd_cnt;
    exp4(15'h1234, 15'h4321, 15'h0002, 15'h0003, 15'h0004, 15'h0005, 15'h0006, 15'h0007);
    send(15'h1234, 15'h4321, 1);
    send(15'h0002, 15'h0003, 0);
    send(15'h0004, 15'h0005, 0);
    send(15'h0006, 15'h0007, 0);
    repeat (2) @(negedge clk);
    chk("t4b_no_pulse_on_boundary", 32'(pd_cnt - p0), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset with a held group and a partial group in flight
    bus.out_ready = 1'b0;
    send(15'h0A01, 15'h0B01, 0);
    send(15'h0A02, 15'h0B02, 0);
    send(15'h0A03, 15'h0B03, 0);
    send(15'h0A04, 15'h0B04, 0);
    send(15'h0C01, 15'h0D01, 0);
    send(15'h0C02, 15'h0D02, 0);
    send(15'h0C03, 15'h0D03, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_O0_real", 32'(bus.O0_real), 32'd0);
    chk("t5_rst_O3_imag", 32'(bus.O3_imag), 32'd0);
    chk("t5_rst_partial_drop", 32'(bus.partial_drop), 32'd0);
    chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    p0 = pd_cnt;
    exp4(15'h0E01, 15'h0F01, 15'h0E02, 15'h0F02, 15'h0E03, 15'h0F03, 15'h0E04, 15'h0F04);
    send(15'h0E01, 15'h0F01, 0);
    send(15'h0E02, 15'h0F02, 0);
    send(15'h0E03, 15'h0F03, 0);
    send(15'h0E04, 15'h0F04, 0);
    repeat (2) @(negedge clk);
    chk("t5_no_drop_after_rst", 32'(pd_cnt - p0), 32'd0);
    @(posedge clk); #1;

    // Lane order check (bit-reversed build expects O = 1,3,2,4)
    exp4(15'd1, 15'd0, 15'd2, 15'd0, 15'd3, 15'd0, 15'd4, 15'd0);
    send(15'd1, 15'd0, 0);
    send(15'd2, 15'd0, 0);
    send(15'd3, 15'd0, 0);
    send(15'd4, 15'd0, 0);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
